// File: rtl/skyline_layer.sv
// Per-layer skyline generator: column LFSR heights, scroll base, vertical row schedule, registered hit/border.
// Optional lit-window output is built only when SKYLINE_WINDOWS_EN is defined; otherwise window is tied 0.
module skyline_layer #(
    parameter int         COL_W_LOG2 = 3,
    parameter int         ROW_HEIGHT = 16,
    parameter int         BASE_LINE  = 116,
    parameter int         SCROLL_DIV = 1,
    parameter logic [8:0] LFSR_SEED  = 9'h1FF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic [9:0] vcount,
    output logic       hit,
    output logic       border,
    output logic       window
);

    localparam int            CW       = COL_W_LOG2;
    localparam logic [CW-1:0] COL_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [3:0]    ROW_LAST = 4'(ROW_HEIGHT - 1);
    localparam logic [3:0]    DIV_LAST = 4'(SCROLL_DIV - 1);
    localparam logic [9:0]    BASE_V   = 10'(BASE_LINE);

    function automatic logic [8:0] lfsr_step(input logic [8:0] v);
        return {v[7:0], v[8] ^ v[4]};
    endfunction

    logic [8:0]    lfsr_q, lfsr_d, lfsr_b_q, lfsr_b_d;
    logic [CW-1:0] col_q, col_d, col_b_q, col_b_d;
    logic [3:0]    div_cnt_q, div_cnt_d;
    logic [4:0]    cutoff_q, cutoff_d;
    logic [3:0]    row_line_q, row_line_d;
    logic          started_q, started_d;
    logic          hit_q, border_q;
    logic          hit_cond, border_cond;

    // Horizontal walk: a line reload overrides pixel stepping in the same cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        col_d  = col_q;
        if (line_start) begin
            lfsr_d = lfsr_b_q;
            col_d  = col_b_q;
        end else if (pix_en) begin
            col_d = col_q + 1'b1;
            if (col_q == COL_MAX) begin
                lfsr_d = lfsr_step(lfsr_q);
            end
        end
    end

    always_comb begin
        lfsr_b_d  = lfsr_b_q;
        col_b_d   = col_b_q;
        div_cnt_d = div_cnt_q;
        if (frame_start) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                col_b_d   = col_b_q + 1'b1;
                if (col_b_q == COL_MAX) begin
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Vertical schedule: frame_start clears, BASE_LINE arms, each completed row raises the cutoff.
    always_comb begin
        cutoff_d   = cutoff_q;
        row_line_d = row_line_q;
        started_d  = started_q;
        if (frame_start) begin
            cutoff_d   = '0;
            row_line_d = '0;
            started_d  = 1'b0;
        end else if (line_start) begin
            if (vcount == BASE_V) begin
                started_d  = 1'b1;
                cutoff_d   = 5'd1;
                row_line_d = '0;
            end else if (started_q) begin
                if (row_line_q == ROW_LAST) begin
                    row_line_d = '0;
                    if (cutoff_q < 5'd16) begin
                        cutoff_d = cutoff_q + 1'b1;
                    end
                end else begin
                    row_line_d = row_line_q + 1'b1;
                end
            end
        end
    end

    assign hit_cond    = ({1'b0, lfsr_q[3:0]} < cutoff_q);
    assign border_cond = hit_cond && started_q &&
                         ((col_q <= COL_ONE) || (row_line_q == 4'd0) || (row_line_q == ROW_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q     <= LFSR_SEED;
            lfsr_b_q   <= LFSR_SEED;
            col_q      <= '0;
            col_b_q    <= '0;
            div_cnt_q  <= '0;
            cutoff_q   <= '0;
            row_line_q <= '0;
            started_q  <= 1'b0;
            hit_q      <= 1'b0;
            border_q   <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            lfsr_b_q   <= lfsr_b_d;
            col_q      <= col_d;
            col_b_q    <= col_b_d;
            div_cnt_q  <= div_cnt_d;
            cutoff_q   <= cutoff_d;
            row_line_q <= row_line_d;
            started_q  <= started_d;
            hit_q      <= pix_en & hit_cond;
            border_q   <= pix_en & border_cond;
        end
    end

    assign hit    = hit_q;
    assign border = border_q;

`ifdef SKYLINE_WINDOWS_EN
    logic window_q;
    logic window_cond;

    // Windows on odd columns and alternate line pairs; lfsr bit 4..7 picks lit/unlit per row band.
    assign window_cond = hit_cond && !border_cond && col_q[0] && row_line_q[1] &&
                         lfsr_q[{2'b01, row_line_q[3:2]}];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_q <= 1'b0;
        end else begin
            window_q <= pix_en & window_cond;
        end
    end

    assign window = window_q;
`else
    assign window = 1'b0;
`endif

endmodule
